block_xfer_control_unit: RTL
============================

// Module: block_xfer_control_unit
// PURPOSE
// - ID-stage control unit, next generation: same decode (MEM/ARITHMETIC/BRANCH) plus sequenced LDM/STM block transfers.
// - A block transfer is expanded into one single-register beat per set bit of reg_list, lowest register first.
// - Emits per-beat EX control, the transfer register and a byte offset from base.
// - Asserts stall to hold IF/ID while beats remain.
// PARAMETERS
// - REG_LIST_W  16  register-list width = architectural register count
// - REG_ADDR_W  4   register index width, clog2(REG_LIST_W)
// - WORD_BYTES  4   address step per beat
// - OFF_W       8   signed offset width, must hold +/-(REG_LIST_W-1)*WORD_BYTES
// - EX_CMD_W    4   EX_command width
// PORTS
// - clk        in   1           clock, rising edge
// - rst        in   1           reset, asynchronous, active-high
// - id_valid   in   1           ID holds a valid instruction
// - freeze     in   1           hazard-unit stall: hold all state, outputs stay stable
// - S          in   1           S bit; load/store select (1=load) in MEM mode
// - mode       in   2           instruction mode field
// - op_code    in   4           arithmetic opcode
// - blk        in   1           MEM-mode instruction is block transfer (LDM/STM)
// - up         in   1           block direction: 1 = increment, 0 = decrement
// - reg_list   in   REG_LIST_W  block register list
// - SR_update  out  1           = S in ARITHMETIC mode, else 0
// - has_src1   out  1           0 for MOV, MVN, branch; 1 otherwise
// - mem_read   out  1           load beat
// - mem_write  out  1           store beat
// - WB_en      out  1           register write-back
// - B          out  1           branch
// - EX_command out  EX_CMD_W    execute command
// - xfer_reg   out  REG_ADDR_W  register index of the current beat (0 when not a block transfer)
// - addr_off   out  OFF_W       signed byte offset of the current beat from base
// - stall      out  1           hold IF/ID; further beats follow
// - last_beat  out  1           current beat is the final beat of a block transfer
// BEHAVIOUR
// - States: IDLE, SEQ.
// - Latched registers: rem_list[REG_LIST_W], beat_idx[REG_ADDR_W], l_S, l_up.
// - Reset (async): state=IDLE, rem_list=0, beat_idx=0.
// - While rst is high, all outputs are 0, including EX_command = `EX_NOP (4'b0000).
// - IDLE, non-block decode (combinational, zero latency):
//   - MEM: S=0 -> EX_STR with mem_write; S=1 -> EX_LDR with mem_read and WB_en.
//   - ARITH: MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR -> matching EX_* with WB_en.
//   - ARITH: CMP/TST -> EX_* only, no WB_en.
//   - Undefined opcode -> EX_NOP, all enables 0.
//   - BRANCH -> B=1.
//   - id_valid=0 -> every output 0.
// - IDLE, blk=1 and mode=MEM and id_valid=1, with n = popcount(reg_list):
//   - n=0: NOP; all outputs 0, no stall.
//   - n=1: single beat at addr_off=0; xfer_reg = index of the set bit; last_beat=1; stall=0; stays IDLE.
//   - n>=2: beat 0 issued this cycle with stall=1, last_beat=0.
//     - If freeze=0: rem_list = reg_list with the lowest set bit cleared; beat_idx=1; latch S and up; go to SEQ.
// - SEQ, per cycle:
//   - xfer_reg = lowest set bit of rem_list.
//   - addr_off = l_up ? +beat_idx*WORD_BYTES : -beat_idx*WORD_BYTES.
//   - EX_command, mem_read, mem_write and WB_en follow l_S.
//   - ID inputs are ignored.
//   - If freeze=0: clear that bit; beat_idx++.
//   - stall = (popcount(rem_list) > 1).
//   - last_beat = (popcount(rem_list) == 1). On the last beat with freeze=0, go to IDLE.
// - freeze=1 in any state: no register updates; outputs repeat the same beat.
// - Base-register writeback (W bit) is not supported; the base is never written.
// - Reset asserted mid-SEQ: the sequence aborts immediately and the remaining beats are dropped.
// STRUCTURE
// - constants.h: MODE_*, OP_*, EX_* (EX_NOP added), ST_IDLE/ST_SEQ encodings.
// - Sub-module lowest_set_bit_enc #(REG_LIST_W): reg_list -> {found, index}.
//   - Used for both the IDLE first beat and the SEQ beats.
// - Popcount compare: local function returning (==0, ==1, >1).
// TESTING
// - Reset: rst=1 mid-stimulus -> all outputs 0, EX_command=EX_NOP; release -> IDLE decode resumes.
// - Decode: ADD -> EX_ADD, WB_en=1. CMP -> EX_CMP, WB_en=0. MOV -> has_src1=0. B -> B=1, has_src1=0. Undefined -> NOP.
// - LDM up, reg_list=16'h8025:
//   - Beats r0/0, r2/+4, r5/+8, r15/+12 on 4 consecutive cycles.
//   - mem_read=WB_en=1; stall=1,1,1,0; last_beat only on the 4th beat.
// - STM down, reg_list=16'h0006: beats r1/0, r2/-4; mem_write=1; stall=1 then 0.
// - Edge lists: reg_list=0 -> no mem op, no stall. reg_list=16'h0010 -> single r4 beat, last_beat=1, stall=0.
// - Freeze and abort:
//   - freeze=1 for 3 cycles during beat 2 of 16'h000F -> beat 2 held with identical outputs; resumes at r2/+8.
//   - rst pulse during beat 2 -> IDLE; next ADD decodes normally.

Source files
------------

// File: rtl/block_xfer_control_unit_pkg.sv
// Shared encodings and decode helpers for the block-transfer ID-stage control unit.
// Mode, opcode and EX command constants plus the FSM state type.
package block_xfer_control_unit_pkg;

  localparam int REG_LIST_W = 16;
  localparam int REG_ADDR_W = 4;
  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = 8;
  localparam int EX_CMD_W   = 4;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [EX_CMD_W-1:0] EX_NOP = 4'b0000;
  localparam logic [EX_CMD_W-1:0] EX_MOV = 4'b0001;
  localparam logic [EX_CMD_W-1:0] EX_ADD = 4'b0010;
  localparam logic [EX_CMD_W-1:0] EX_ADC = 4'b0011;
  localparam logic [EX_CMD_W-1:0] EX_SUB = 4'b0100;
  localparam logic [EX_CMD_W-1:0] EX_SBC = 4'b0101;
  localparam logic [EX_CMD_W-1:0] EX_AND = 4'b0110;
  localparam logic [EX_CMD_W-1:0] EX_ORR = 4'b0111;
  localparam logic [EX_CMD_W-1:0] EX_EOR = 4'b1000;
  localparam logic [EX_CMD_W-1:0] EX_MVN = 4'b1001;
  localparam logic [EX_CMD_W-1:0] EX_CMP = 4'b0100;
  localparam logic [EX_CMD_W-1:0] EX_TST = 4'b0110;
  localparam logic [EX_CMD_W-1:0] EX_LDR = 4'b0010;
  localparam logic [EX_CMD_W-1:0] EX_STR = 4'b0010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic                ok;
    logic [EX_CMD_W-1:0] ex;
    logic                wb;
    logic                src1;
  } arith_dec_t;

  function automatic arith_dec_t arith_decode(input logic [3:0] op);
    arith_dec_t d;
    d = '{ok: 1'b1, ex: EX_NOP, wb: 1'b1, src1: 1'b1};
    case (op)
      OP_MOV:  begin d.ex = EX_MOV; d.src1 = 1'b0; end
      OP_MVN:  begin d.ex = EX_MVN; d.src1 = 1'b0; end
      OP_ADD:  d.ex = EX_ADD;
      OP_ADC:  d.ex = EX_ADC;
      OP_SUB:  d.ex = EX_SUB;
      OP_SBC:  d.ex = EX_SBC;
      OP_AND:  d.ex = EX_AND;
      OP_ORR:  d.ex = EX_ORR;
      OP_EOR:  d.ex = EX_EOR;
      OP_CMP:  begin d.ex = EX_CMP; d.wb = 1'b0; end
      OP_TST:  begin d.ex = EX_TST; d.wb = 1'b0; end
      default: d = '{ok: 1'b0, ex: EX_NOP, wb: 1'b0, src1: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/block_xfer_control_unit_if.sv
// ID-stage instruction fields in, EX control and block-transfer beat info out.
interface block_xfer_control_unit_if;
  import block_xfer_control_unit_pkg::*;

  logic                  id_valid;
  logic                  freeze;
  logic                  S;
  logic [1:0]            mode;
  logic [3:0]            op_code;
  logic                  blk;
  logic                  up;
  logic [REG_LIST_W-1:0] reg_list;

  logic                  SR_update;
  logic                  has_src1;
  logic                  mem_read;
  logic                  mem_write;
  logic                  WB_en;
  logic                  B;
  logic [EX_CMD_W-1:0]   EX_command;
  logic [REG_ADDR_W-1:0] xfer_reg;
  logic [OFF_W-1:0]      addr_off;
  logic                  stall;
  logic                  last_beat;

  modport master (
    output id_valid, freeze, S, mode, op_code, blk, up, reg_list,
    input  SR_update, has_src1, mem_read, mem_write, WB_en, B,
           EX_command, xfer_reg, addr_off, stall, last_beat
  );

  modport slave (
    input  id_valid, freeze, S, mode, op_code, blk, up, reg_list,
    output SR_update, has_src1, mem_read, mem_write, WB_en, B,
           EX_command, xfer_reg, addr_off, stall, last_beat
  );
endinterface

// File: rtl/lowest_set_bit_enc.sv
// Priority encoder: reports whether any bit is set and the index of the lowest one.
module lowest_set_bit_enc #(
  parameter int W = 16
) (
  input  logic [W-1:0]                           vec,
  output logic                                   found,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0]   index
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  // Scan high to low so the lowest set bit is the final value written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      index = vec[i] ? IW'(i) : index;
      found = found | vec[i];
    end
  end
endmodule

// File: rtl/block_xfer_control_unit.sv
// ID-stage control unit: single-cycle decode plus LDM/STM expansion into
// one register beat per cycle, lowest register first, holding IF/ID meanwhile.
module block_xfer_control_unit
  import block_xfer_control_unit_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  block_xfer_control_unit_if.slave bus
);
  typedef struct packed {
    logic zero;
    logic one;
    logic many;
  } pop_cls_t;

  function automatic pop_cls_t pop_classify(input logic [REG_LIST_W-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < REG_LIST_W; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return '{zero: (cnt == 32'd0), one: (cnt == 32'd1), many: (cnt > 32'd1)};
  endfunction

  state_t                state_r, state_n;
  logic [REG_LIST_W-1:0] rem_list_r, rem_list_n, sel_vec_s;
  logic [REG_ADDR_W-1:0] beat_idx_r, beat_idx_n, lsb_idx_s;
  logic                  l_s_r, l_s_n, l_up_r, l_up_n;
  logic                  lsb_found_s, mem_s, load_s;
  pop_cls_t              pop_s;
  arith_dec_t            dec_s;
  logic [OFF_W-1:0]      off_mag_s;

  logic                  sr_s, src1_s, rd_s, wr_s, wb_s, b_s, stall_s, last_s;
  logic [EX_CMD_W-1:0]   ex_s;
  logic [REG_ADDR_W-1:0] xr_s;
  logic [OFF_W-1:0]      off_s;

  // One encoder serves both the first beat (from ID) and the sequenced beats.
  assign sel_vec_s = (state_r == ST_SEQ) ? rem_list_r : bus.reg_list;
  assign pop_s     = pop_classify(sel_vec_s);
  assign dec_s     = arith_decode(bus.op_code);
  assign off_mag_s = OFF_W'(beat_idx_r) * OFF_W'(WORD_BYTES);

  lowest_set_bit_enc #(.W(REG_LIST_W)) u_lsb (
    .vec   (sel_vec_s),
    .found (lsb_found_s),
    .index (lsb_idx_s)
  );

  // Next-state and per-beat control decode.
  always_comb begin
    state_n    = state_r;
    rem_list_n = rem_list_r;
    beat_idx_n = beat_idx_r;
    l_s_n      = l_s_r;
    l_up_n     = l_up_r;
    mem_s      = 1'b0;
    load_s     = 1'b0;
    sr_s       = 1'b0;
    src1_s     = 1'b0;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    wb_s       = 1'b0;
    b_s        = 1'b0;
    ex_s       = EX_NOP;
    xr_s       = '0;
    off_s      = '0;
    stall_s    = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.id_valid) begin
          case (bus.mode)
            MODE_MEM: begin
              if (!bus.blk) begin
                mem_s  = 1'b1;
                load_s = bus.S;
              end else if (lsb_found_s) begin
                mem_s   = 1'b1;
                load_s  = bus.S;
                xr_s    = lsb_idx_s;
                last_s  = pop_s.one;
                stall_s = pop_s.many;
                if (pop_s.many && !bus.freeze) begin
                  state_n    = ST_SEQ;
                  rem_list_n = bus.reg_list & (bus.reg_list - REG_LIST_W'(1));
                  beat_idx_n = REG_ADDR_W'(1);
                  l_s_n      = bus.S;
                  l_up_n     = bus.up;
                end else begin
                  state_n = ST_IDLE;
                end
              end else begin
                mem_s = 1'b0;
              end
            end
            MODE_ARITH: begin
              if (dec_s.ok) begin
                ex_s   = dec_s.ex;
                wb_s   = dec_s.wb;
                src1_s = dec_s.src1;
                sr_s   = bus.S;
              end else begin
                ex_s = EX_NOP;
              end
            end
            MODE_BRANCH: b_s = 1'b1;
            default:     b_s = 1'b0;
          endcase
        end else begin
          mem_s = 1'b0;
        end
      end
      ST_SEQ: begin
        mem_s   = 1'b1;
        load_s  = l_s_r;
        xr_s    = lsb_idx_s;
        off_s   = l_up_r ? off_mag_s : -off_mag_s;
        stall_s = pop_s.many;
        last_s  = pop_s.one;
        if (pop_s.zero) begin
          // Unreachable in normal operation; recover to IDLE rather than hang.
          mem_s   = 1'b0;
          xr_s    = '0;
          off_s   = '0;
          state_n = ST_IDLE;
        end else if (!bus.freeze) begin
          rem_list_n = rem_list_r & (rem_list_r - REG_LIST_W'(1));
          beat_idx_n = beat_idx_r + REG_ADDR_W'(1);
          state_n    = pop_s.one ? ST_IDLE : ST_SEQ;
        end else begin
          state_n = ST_SEQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (mem_s) begin
      src1_s = 1'b1;
      rd_s   = load_s;
      wr_s   = !load_s;
      wb_s   = load_s;
      ex_s   = load_s ? EX_LDR : EX_STR;
    end else begin
      src1_s = src1_s;
    end
  end

  // Sequencer state; reset drops any in-flight block transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rem_list_r <= '0;
      beat_idx_r <= '0;
      l_s_r      <= 1'b0;
      l_up_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      rem_list_r <= rem_list_n;
      beat_idx_r <= beat_idx_n;
      l_s_r      <= l_s_n;
      l_up_r     <= l_up_n;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    if (rst) begin
      bus.SR_update  = 1'b0;
      bus.has_src1   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.WB_en      = 1'b0;
      bus.B          = 1'b0;
      bus.EX_command = EX_NOP;
      bus.xfer_reg   = '0;
      bus.addr_off   = '0;
      bus.stall      = 1'b0;
      bus.last_beat  = 1'b0;
    end else begin
      bus.SR_update  = sr_s;
      bus.has_src1   = src1_s;
      bus.mem_read   = rd_s;
      bus.mem_write  = wr_s;
      bus.WB_en      = wb_s;
      bus.B          = b_s;
      bus.EX_command = ex_s;
      bus.xfer_reg   = xr_s;
      bus.addr_off   = off_s;
      bus.stall      = stall_s;
      bus.last_beat  = last_s;
    end
  end
endmodule
